linear_out_collector: RTL

- Sink for the linear layer's serial result stream: accepts one ACC_WIDTH signed dot product per in_valid pulse, M per frame.
- Requantizes each result to DATA_WIDTH (round, arithmetic shift, saturate) and stores it in an M-entry buffer.
- Presents the full buffer as a parallel activation vector, with a valid/ready handshake, to the next layer or sequencer.
- The upstream producer has no backpressure, so overrun and short frames are flagged, not stalled.

---
 rtl/linear_out_collector_if.sv | 27 ++
 rtl/linear_out_collector.sv | 134 +++++++++++++
 2 files changed

// File: rtl/linear_out_collector_if.sv
// Bundle between the linear layer's result stream, the collector and the downstream consumer.
// The collector takes the slave modport; the producer/consumer side takes master.
interface linear_out_collector_if #(
   parameter int ACC_WIDTH  = 32,
   parameter int DATA_WIDTH = 8,
   parameter int M          = 8,
   parameter int CNT_W      = $clog2(M + 1)
);
   logic signed [ACC_WIDTH-1:0] in_data;
   logic                        in_valid;
   logic                        in_done;
   logic [M*DATA_WIDTH-1:0]     act_out;
   logic                        act_valid;
   logic                        act_ready;
   logic [CNT_W-1:0]            fill_count;
   logic                        err;

   modport master (
      output in_data, in_valid, in_done, act_ready,
      input  act_out, act_valid, fill_count, err
   );

   modport slave (
      input  in_data, in_valid, in_done, act_ready,
      output act_out, act_valid, fill_count, err
   );
endinterface

// File: rtl/linear_out_collector.sv
// Collects M requantized linear-layer results into a buffer and hands them on as one vector.
// Define LINEAR_OUT_RELU_EN to clamp negative activations to zero before storing.
module linear_out_collector #(
   parameter int ACC_WIDTH  = 32,
   parameter int DATA_WIDTH = 8,
   parameter int M          = 8,
   parameter int SHIFT      = 8,
   parameter int CNT_W      = $clog2(M + 1)
) (
   input  logic               clk,
   input  logic               rst,
   linear_out_collector_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

   localparam int AW = ACC_WIDTH + 1;
   localparam logic signed [AW-1:0] RND    = (SHIFT == 0) ? '0
                                             : (AW'(1) <<< ((SHIFT == 0) ? 0 : SHIFT - 1));
   localparam logic signed [AW-1:0] SAT_HI = AW'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
   localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

   state_t                        state_q, state_d;
   logic [CNT_W-1:0]              fill_q, fill_d;
   logic                          valid_q, valid_d;
   logic                          err_q, err_d;
   logic                          done_q, done_d;
   logic signed [DATA_WIDTH-1:0]  buf_q [M];
   logic signed [DATA_WIDTH-1:0]  buf_d [M];

   logic signed [AW-1:0]          ext, rounded, shifted;
   logic signed [DATA_WIDTH-1:0]  q_val;
   logic                          take, wr_en, done_rise;
   logic [CNT_W-1:0]              base, wr_idx;
   logic [M*DATA_WIDTH-1:0]       act_vec;

   // Requantize: round half toward +inf, arithmetic shift, saturate.
   always_comb begin
      ext     = {bus.in_data[ACC_WIDTH-1], bus.in_data};
      rounded = ext + RND;
      shifted = rounded >>> SHIFT;
      if (shifted > SAT_HI)      q_val = SAT_HI[DATA_WIDTH-1:0];
      else if (shifted < SAT_LO) q_val = SAT_LO[DATA_WIDTH-1:0];
      else                       q_val = shifted[DATA_WIDTH-1:0];
`ifdef LINEAR_OUT_RELU_EN
      if (q_val[DATA_WIDTH-1]) q_val = '0;
`endif
   end

   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      valid_d   = valid_q;
      err_d     = err_q;
      done_d    = bus.in_done;
      done_rise = bus.in_done & ~done_q;
      take      = 1'b0;
      base      = '0;
      wr_en     = 1'b0;
      wr_idx    = '0;

      case (state_q)
         S_IDLE: begin
            take = bus.in_valid;
         end
         S_COLLECT: begin
            take = bus.in_valid;
            base = fill_q;
         end
         S_HOLD: begin
            // A sample arriving in the handshake cycle opens the next frame.
            if (bus.act_ready) begin
               valid_d = 1'b0;
               fill_d  = '0;
               state_d = S_IDLE;
               take    = bus.in_valid;
            end else if (bus.in_valid) begin
               err_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (take) begin
         wr_en  = 1'b1;
         wr_idx = base;
         fill_d = base + 1'b1;
         if (base == CNT_W'(M - 1)) begin
            state_d = S_HOLD;
            valid_d = 1'b1;
         end else begin
            state_d = S_COLLECT;
         end
      end

      // Short-frame check sees the count after this cycle's write.
      if (done_rise && state_d == S_COLLECT) begin
         err_d   = 1'b1;
         fill_d  = '0;
         state_d = S_IDLE;
      end

      for (int k = 0; k < M; k++) begin
         buf_d[k] = buf_q[k];
         if (wr_en && wr_idx == CNT_W'(k)) buf_d[k] = q_val;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         fill_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         for (int k = 0; k < M; k++) buf_q[k] <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         done_q  <= done_d;
         for (int k = 0; k < M; k++) buf_q[k] <= buf_d[k];
      end
   end

   for (genvar gi = 0; gi < M; gi++) begin : g_pack
      assign act_vec[gi*DATA_WIDTH +: DATA_WIDTH] = buf_q[gi];
   end

   assign bus.act_out    = act_vec;
   assign bus.act_valid  = valid_q;
   assign bus.fill_count = fill_q;
   assign bus.err        = err_q;
endmodule
